snax_hwpe_periph_regfile: RTL

Responder end of the HWPE peripheral control protocol. It terminates `hwpe_ctrl_intf_periph` transactions issued by the SNAX HWPE control bridge and holds the accelerator's configuration registers. It runs a job trigger/busy/done state machine toward the datapath engine and returns read data with ID on `r_valid`. It sits between the bridge and the engine, e.g. the MAC.

---
 rtl/snax_hwpe_regfile_pkg.sv | 34 +++
 rtl/hwpe_ctrl_intf_periph.sv | 29 ++
 rtl/snax_hwpe_job_fsm.sv | 59 +++++
 rtl/snax_hwpe_periph_regfile.sv | 128 ++++++++++++
 4 files changed

// File: rtl/snax_hwpe_regfile_pkg.sv
// Shared constants and types for the SNAX HWPE peripheral register file:
// register map indices, STATUS bit layout and the job FSM state encoding.
package snax_hwpe_regfile_pkg;

    localparam int unsigned RegIdxWidth = 5;

    localparam logic [RegIdxWidth-1:0] TriggerIdx = 5'd0;
    localparam logic [RegIdxWidth-1:0] StatusIdx  = 5'd1;
    localparam logic [RegIdxWidth-1:0] CfgBaseIdx = 5'd2;

    localparam int unsigned StatusBusyBit  = 0;
    localparam int unsigned StatusCntLsb   = 8;
    localparam int unsigned StatusCntWidth = 8;
    localparam int unsigned StatusIrqBit   = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY
    } job_state_e;

    // Replace only the bytes of old_word whose byte-enable bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// HWPE peripheral control bus: request channel (req/gnt) plus a response
// channel (r_valid) that has no back-pressure.
interface hwpe_ctrl_intf_periph #(
    parameter int unsigned IdWidth = 5
);
    logic               req;
    logic [31:0]        add;
    logic               wen;
    logic [3:0]         be;
    logic [31:0]        data;
    logic [IdWidth-1:0] id;
    logic               gnt;
    logic               r_valid;
    logic [31:0]        r_data;
    logic [IdWidth-1:0] r_id;

    // Handshake: a request transfers in the cycle where req && gnt; its single
    // response is r_valid exactly one cycle later and must always be accepted.
    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_valid, r_data, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_valid, r_data, r_id
    );

endinterface

// File: rtl/snax_hwpe_job_fsm.sv
// Job sequencer: IDLE -> START (one-cycle start pulse) -> BUSY until done_i,
// with an 8-bit wrapping completed-job counter.
module snax_hwpe_job_fsm
    import snax_hwpe_regfile_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      trigger_i,
    input  logic                      done_i,
    output logic                      start_o,
    output logic                      busy_o,
    output logic [StatusCntWidth-1:0] count_o,
    output logic                      job_end_o,
    output job_state_e                state_o
);

    job_state_e                state_q, state_d;
    logic [StatusCntWidth-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (job_end_o) count_q <= count_q + 1'b1;
        end
    end

    // done_i only matters in BUSY; a pulse seen in IDLE or START is dropped.
    always_comb begin
        state_d   = state_q;
        start_o   = 1'b0;
        busy_o    = 1'b0;
        job_end_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger_i) state_d = START;
            end
            START: begin
                start_o = 1'b1;
                busy_o  = 1'b1;
                state_d = BUSY;
            end
            BUSY: begin
                busy_o = 1'b1;
                if (done_i) begin
                    job_end_o = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign count_o = count_q;
    assign state_o = state_q;

endmodule

// File: rtl/snax_hwpe_periph_regfile.sv
// Peripheral-bus register file for an HWPE: TRIGGER/STATUS/CONFIG map, job FSM
// and registered responses. SNAX_HWPE_REGFILE_IRQ_EN adds a sticky irq_o.
module snax_hwpe_periph_regfile
    import snax_hwpe_regfile_pkg::*;
#(
    parameter int unsigned NumRegs = 8,
    parameter int unsigned IdWidth = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    hwpe_ctrl_intf_periph.slave       periph,
    output logic [(NumRegs-2)*32-1:0] cfg_o,
    output logic                      start_o,
    output logic                      busy_o,
    input  logic                      done_i
`ifdef SNAX_HWPE_REGFILE_IRQ_EN
    ,
    output logic                      irq_o
`endif
);

    logic [RegIdxWidth-1:0]    idx;
    logic                      is_trigger, is_status, is_cfg, is_write;
    logic                      gnt, trigger, cfg_we, status_rd;
    logic [31:0]               status_word, rdata;
    logic [StatusCntWidth-1:0] job_count;
    logic                      job_end;
    job_state_e                fsm_state_unused;
    logic                      add_unused;

    logic                      r_valid_q;
    logic [31:0]               r_data_q;
    logic [IdWidth-1:0]        r_id_q;
    logic [(NumRegs-2)*32-1:0] cfg_q;

    assign idx        = periph.add[6:2];
    assign add_unused = ^{periph.add[31:7], periph.add[1:0]};
    assign is_trigger = (idx == TriggerIdx);
    assign is_status  = (idx == StatusIdx);
    assign is_cfg     = (idx >= CfgBaseIdx) && ({27'b0, idx} < NumRegs);
    assign is_write   = ~periph.wen;

    // Writes that would disturb a running job stall; everything else is granted.
    assign gnt       = periph.req & ~(is_write & (is_trigger | is_cfg) & busy_o);
    assign trigger   = gnt & is_write & is_trigger & (|periph.be);
    assign cfg_we    = gnt & is_write & is_cfg;
    assign status_rd = gnt & periph.wen & is_status;

    snax_hwpe_job_fsm i_job_fsm (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .trigger_i (trigger),
        .done_i    (done_i),
        .start_o   (start_o),
        .busy_o    (busy_o),
        .count_o   (job_count),
        .job_end_o (job_end),
        .state_o   (fsm_state_unused)
    );

`ifdef SNAX_HWPE_REGFILE_IRQ_EN
    logic irq_q;

    // A completing job wins over a simultaneous clearing STATUS read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        irq_q <= 1'b0;
        else if (job_end)   irq_q <= 1'b1;
        else if (status_rd) irq_q <= 1'b0;
    end

    assign irq_o = irq_q;
`else
    logic status_rd_unused;
    assign status_rd_unused = status_rd;
`endif

    always_comb begin
        status_word                                 = '0;
        status_word[StatusBusyBit]                  = busy_o;
        status_word[StatusCntLsb +: StatusCntWidth] = job_count;
`ifdef SNAX_HWPE_REGFILE_IRQ_EN
        status_word[StatusIrqBit]                   = irq_q;
`endif
    end

    always_comb begin
        rdata = '0;
        if (is_status) begin
            rdata = status_word;
        end else if (is_cfg) begin
            for (int unsigned r = 0; r < NumRegs - 2; r++) begin
                if (idx == RegIdxWidth'(r + CfgBaseIdx)) rdata = cfg_q[r*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q <= '0;
        end else if (cfg_we) begin
            for (int unsigned r = 0; r < NumRegs - 2; r++) begin
                if (idx == RegIdxWidth'(r + CfgBaseIdx)) begin
                    cfg_q[r*32 +: 32] <= byte_merge(cfg_q[r*32 +: 32], periph.data, periph.be);
                end
            end
        end
    end

    // Read data is captured from pre-update state in the grant cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_id_q    <= '0;
        end else begin
            r_valid_q <= gnt;
            r_data_q  <= (gnt && periph.wen) ? rdata : 32'h0;
            r_id_q    <= gnt ? periph.id : '0;
        end
    end

    assign periph.gnt     = gnt;
    assign periph.r_valid = r_valid_q;
    assign periph.r_data  = r_data_q;
    assign periph.r_id    = r_id_q;
    assign cfg_o          = cfg_q;

endmodule
